// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain stage.
package fifo_drain_pkg;

    localparam int BUF_DEPTH = 3;

    typedef logic [1:0]  occ_t;
    typedef logic [15:0] pkt_cnt_t;

    // Circular pointer increment for a 3-entry buffer: 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/stream_buf3.sv
// Three-entry circular skid buffer; push and pop may coincide, including when full.
module stream_buf3
    import fifo_drain_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output occ_t         occ
);

    logic [W-1:0] r_mem [BUF_DEPTH];
    logic [1:0]   r_head;
    logic [1:0]   r_tail;
    occ_t         r_occ;
    logic         w_pop;

    // A pop on an empty buffer is ignored so pointers never run ahead of the data.
    assign w_pop     = pop && (r_occ != 2'd0);
    assign head_data = r_mem[r_head];
    assign occ       = r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= 2'd0;
            r_tail <= 2'd0;
            r_occ  <= 2'd0;
        end else begin
            if (push) begin
                r_mem[r_tail] <= push_data;
                r_tail        <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a synchronous FIFO into a framed valid/ready stream, hiding the FIFO's read latency.
module fifo_stream_drain
    import fifo_drain_pkg::*;
#(
    parameter int W       = 8,
    parameter int PKT_LEN = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         fifo_empty,
    input  logic [W-1:0] fifo_data,
    output logic         fifo_r_en,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output pkt_cnt_t     pkt_count
);

    localparam int                BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic              r_inflight;
    logic [BEAT_W-1:0] r_beat;
    pkt_cnt_t          r_pkt_count;

    occ_t              w_occ;
    logic [2:0]        w_pending;
    logic              w_rd;
    logic              w_xfer;
    logic              w_last;

    // Reads are throttled on buffered plus in-flight words, so m_ready never
    // reaches fifo_r_en combinationally and every issued read has a free slot.
    assign w_pending = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_rd      = rst_n && !fifo_empty && (w_pending < 3'(BUF_DEPTH));
    assign fifo_r_en = w_rd;

    assign m_valid   = (w_occ != 2'd0);
    assign w_last    = m_valid && (r_beat == LAST_BEAT);
    assign m_last    = w_last;
    assign w_xfer    = m_valid && m_ready;
    assign pkt_count = r_pkt_count;

    stream_buf3 #(
        .W (W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_inflight),
        .push_data (fifo_data),
        .pop       (w_xfer),
        .head_data (m_data),
        .occ       (w_occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat      <= '0;
            r_pkt_count <= '0;
        end else if (w_xfer) begin
            if (w_last) begin
                r_beat      <= '0;
                r_pkt_count <= r_pkt_count + 16'd1;
            end else begin
                r_beat      <= r_beat + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: FIFO model, scoreboard of expected beats, table and corner sequences.
module tb_fifo_stream_drain;

    localparam int W       = 8;
    localparam int PKT_LEN = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fifo_empty;
    logic [W-1:0] fifo_data;
    logic         fifo_r_en;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic         m_last;
    logic [15:0]  pkt_count;

    fifo_stream_drain #(.W(W), .PKT_LEN(PKT_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    // Synchronous FIFO model: one-cycle read latency, cleared by the shared reset.
    logic [W-1:0] fmem [256];
    logic [7:0]   wp = 8'd0;
    logic [7:0]   rp;
    assign fifo_empty = (wp == rp);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp        <= 8'd0;
            fifo_data <= '0;
        end else if (fifo_r_en && !fifo_empty) begin
            fifo_data <= fmem[rp];
            rp        <= rp + 8'd1;
        end
    end

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;
    exp_t sb_new;
    int   exp_beat = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   xfer_cnt = 0;
    int   rd_cnt   = 0;
    int   viol     = 0;

    logic         pv = 1'b0;
    logic         pr = 1'b0;
    logic [W-1:0] pd = '0;
    logic         pl = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        fmem[wp] = d;
        wp       = wp + 8'd1;
        sb_new.d = d;
        sb_new.l = (exp_beat == PKT_LEN - 1);
        exp_q.push_back(sb_new);
        exp_beat = (exp_beat == PKT_LEN - 1) ? 0 : exp_beat + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        m_ready  = 1'b0;
        wp       = 8'd0;
        exp_q.delete();
        exp_beat = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_drain(input bit rand_ready);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !m_valid) break;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
        chk("drain_complete", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (fifo_r_en) rd_cnt++;
            if (fifo_r_en && fifo_empty) viol++;
            if (pv && !pr && (!m_valid || m_data !== pd || m_last !== pl)) viol++;
            if (m_valid && m_ready) begin
                xfer_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: actual data 0x%0h, required no transfer", m_data);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (m_data !== sb_e.d || m_last !== sb_e.l) begin
                        errors++;
                        $display("FAIL sb_word: actual data 0x%0h last %b, required data 0x%0h last %b",
                                 m_data, m_last, sb_e.d, sb_e.l);
                    end
                end
            end
            pv = m_valid;
            pr = m_ready;
            pd = m_data;
            pl = m_last;
        end
    end

    typedef struct {
        logic         rdy;
        logic         exp_ren;
        logic         exp_vld;
        logic [W-1:0] exp_data;
        logic         exp_last;
    } vec_t;

    vec_t vt [5];

    initial begin
        int rd0;
        int xf0;
        int pushed;

        // Single word: cycle c has fifo_empty low, m_valid follows two cycles later.
        vt[0] = '{rdy: 1'b1, exp_ren: 1'b1, exp_vld: 1'b0, exp_data: 8'h00, exp_last: 1'b0};
        vt[1] = '{rdy: 1'b1, exp_ren: 1'b0, exp_vld: 1'b0, exp_data: 8'h00, exp_last: 1'b0};
        vt[2] = '{rdy: 1'b1, exp_ren: 1'b0, exp_vld: 1'b1, exp_data: 8'hA5, exp_last: 1'b0};
        vt[3] = '{rdy: 1'b1, exp_ren: 1'b0, exp_vld: 1'b0, exp_data: 8'h00, exp_last: 1'b0};
        vt[4] = '{rdy: 1'b1, exp_ren: 1'b0, exp_vld: 1'b0, exp_data: 8'h00, exp_last: 1'b0};

        // Reset state, with the FIFO model looking non-empty to prove fifo_r_en is gated.
        rst_n = 1'b0;
        wp    = 8'd1;
        #12;
        chk("rst_r_en", 32'(fifo_r_en), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        do_reset();

        rd0     = rd_cnt;
        m_ready = 1'b1;
        push_word(8'hA5);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            m_ready = vt[i].rdy;
            @(negedge clk);
            #1;
            chk($sformatf("single_r_en[%0d]", i), 32'(fifo_r_en), 32'(vt[i].exp_ren));
            chk($sformatf("single_valid[%0d]", i), 32'(m_valid), 32'(vt[i].exp_vld));
            if (vt[i].exp_vld) begin
                chk($sformatf("single_data[%0d]", i), 32'(m_data), 32'(vt[i].exp_data));
                chk($sformatf("single_last[%0d]", i), 32'(m_last), 32'(vt[i].exp_last));
            end
        end
        chk("single_reads", 32'(rd_cnt - rd0), 32'd1);

        // Streaming: eight back-to-back transfers starting two cycles after the push.
        do_reset();
        m_ready = 1'b1;
        xf0     = xfer_cnt;
        for (int i = 1; i <= 8; i++) push_word(8'(i));
        repeat (10) @(negedge clk);
        #1;
        chk("stream_xfers", 32'(xfer_cnt - xf0), 32'd8);
        step();
        chk("stream_pkt", 32'(pkt_count), 32'd2);
        chk("stream_empty_q", 32'(exp_q.size()), 32'd0);

        // Backpressure: three reads fill the buffer, head holds, then a gapless drain.
        do_reset();
        m_ready = 1'b0;
        rd0     = rd_cnt;
        for (int i = 1; i <= 8; i++) push_word(8'(i));
        repeat (8) step();
        chk("bp_reads", 32'(rd_cnt - rd0), 32'd3);
        chk("bp_valid", 32'(m_valid), 32'd1);
        chk("bp_data", 32'(m_data), 32'h01);
        chk("bp_r_en_low", 32'(fifo_r_en), 32'd0);
        step();
        chk("bp_data_hold", 32'(m_data), 32'h01);
        m_ready = 1'b1;
        xf0     = xfer_cnt;
        repeat (8) @(negedge clk);
        #1;
        chk("bp_gapless", 32'(xfer_cnt - xf0), 32'd8);
        step();
        chk("bp_done_valid", 32'(m_valid), 32'd0);
        chk("bp_pkt", 32'(pkt_count), 32'd2);

        // Random m_ready and bursty FIFO fill over 64 words.
        do_reset();
        pushed = 0;
        while (pushed < 64) begin
            if ($urandom_range(0, 1) == 1) begin
                push_word(8'(pushed * 7 + 3));
                pushed++;
            end
            m_ready = 1'($urandom_range(0, 1));
            step();
        end
        wait_drain(1'b1);
        chk("rand_pkt", 32'(pkt_count), 32'd16);
        chk("protocol_violations", 32'(viol), 32'd0);

        // Reset mid-operation with two words buffered at beat 2.
        do_reset();
        m_ready = 1'b1;
        push_word(8'h31);
        push_word(8'h32);
        repeat (4) step();
        m_ready = 1'b0;
        push_word(8'h33);
        push_word(8'h34);
        repeat (4) step();
        chk("mid_pre_valid", 32'(m_valid), 32'd1);
        chk("mid_pre_data", 32'(m_data), 32'h33);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_last", 32'(m_last), 32'd0);
        chk("mid_rst_data", 32'(m_data), 32'd0);
        chk("mid_rst_r_en", 32'(fifo_r_en), 32'd0);
        chk("mid_rst_pkt", 32'(pkt_count), 32'd0);
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'(8'h10 + i));
        wait_drain(1'b0);
        chk("mid_post_pkt", 32'(pkt_count), 32'd1);

        // Packet counter wrap from 0xFFFF.
        do_reset();
        force dut.r_pkt_count = 16'hFFFF;
        #1;
        release dut.r_pkt_count;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_word(8'(8'hC0 + i));
        wait_drain(1'b0);
        chk("pkt_wrap", 32'(pkt_count), 32'd0);

        chk("final_violations", 32'(viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule

// File: doc/fifo_stream_drain.md
# fifo_stream_drain

Read-side drain stage that sits directly downstream of `synchronous_fifo`. It pulls words through the FIFO's `r_en`/`empty`/`data_out` port and re-presents them as a valid/ready stream with packet framing, so consumers never see the FIFO's one-cycle read latency. A 3-entry internal buffer absorbs in-flight reads and sustains one word per cycle with no combinational path from `m_ready` to `fifo_r_en`.

## Interface
- `W`, default 8: data width; must match the FIFO's `W`.
- `PKT_LEN`, default 4: beats per packet; `m_last` marks beat `PKT_LEN-1`. Legal range is 1..256.
- `clk`  in  1  single clock, shared with the FIFO.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_data`  in  W  FIFO `data_out`, valid the cycle after an accepted read.
- `fifo_r_en`  out  1  FIFO `r_en`.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  W  stream word.
- `m_last`  out  1  last beat of the current packet.
- `pkt_count`  out  16  packets completed since reset; wraps modulo 2^16.

## Operation
- **FIFO contract:** a read is issued when `fifo_r_en` is high at a clk edge. The FIFO never sees `fifo_r_en` high while `fifo_empty` is high. The word appears on `fifo_data` in the following cycle.
- **`inflight`:** a register equal to `fifo_r_en` from the previous cycle. `occ` (0..3) is the number of buffered words.
- **Read issue:** `fifo_r_en = rst_n && !fifo_empty && (occ + inflight) < 3`. It is built from registers and `fifo_empty` only.
- **Capture:** when `inflight` is 1, `fifo_data` is written at the buffer tail on that clock edge.
- **Output:**
  - `m_valid = (occ != 0)`.
  - `m_data` is the buffer head.
  - A transfer occurs when `m_valid && m_ready`; the head pops on that edge.
  - Capture and pop in the same cycle leave `occ` unchanged.
- **Valid/ready rule:** once `m_valid` is high, `m_valid`, `m_data` and `m_last` hold stable until the transfer. `m_valid` never drops without a transfer.
- **Beat counter:** `beat` (width `$clog2(PKT_LEN)`, minimum 1) counts transfers.
  - `m_last = m_valid && (beat == PKT_LEN-1)`.
  - On a transfer with `m_last` set, `beat` goes to 0 and `pkt_count` increments.
  - With `PKT_LEN == 1`, `m_last` equals `m_valid`.
- **Reset values** (`rst_n` low, asynchronous):
  - `occ`, `inflight`, `beat`, `pkt_count` = 0.
  - `m_valid` = 0, `m_last` = 0, `m_data` = 0.
  - `fifo_r_en` is forced to 0 while `rst_n` is low.
- **Reset mid-operation:** buffered and in-flight words are discarded and framing restarts at beat 0. The FIFO shares `rst_n` and is cleared with this block.

## Timing
- **First-word latency:** if `fifo_empty` falls so that it is low in cycle c, then:
  - `fifo_r_en` is high in cycle c;
  - `fifo_data` is valid in cycle c+1;
  - `m_valid` is high in cycle c+2.
- **Steady state** (`m_ready` = 1, FIFO non-empty): one read and one transfer per cycle; `occ` = 1 and `inflight` = 1.
- **Backpressure** (`m_ready` = 0): at most 3 further reads are issued, then `fifo_r_en` stays low with `occ` = 3.
  - When `m_ready` rises in cycle r, words leave in cycles r, r+1, r+2 with no bubble.
  - Reads resume in cycle r+1, because `occ + inflight` drops below 3 after the first pop.
- **FIFO goes empty:** `fifo_r_en` drops in the same cycle. Buffered words continue to drain.
- **Order:** words leave in exactly FIFO order, with no duplication and no loss.

## Structure
- **Package `fifo_drain_pkg`:**
  - `localparam int BUF_DEPTH = 3`.
  - `typedef logic [1:0] occ_t`.
  - `typedef logic [15:0] pkt_cnt_t`.
- **Sub-module `stream_buf3`:** a 3-entry circular buffer.
  - Ports: push, push_data, pop, head_data, occ.
  - Head/tail pointers wrap 2 -> 0.
  - Push and pop in the same cycle are allowed, including at `occ` = 3 with a pop.
- **Top level:** holds the read-issue logic, the `inflight` register, the beat counter and `pkt_count`.

## Test plan
- **Single word:** reset for 2 cycles, FIFO preloaded with 0xA5, `m_ready` = 1 -> `m_valid` rises 2 cycles after the first cycle with `fifo_empty` low; `m_data` = 0xA5; `fifo_r_en` pulses once.
- **Streaming:** FIFO holds 0x01..0x08, `PKT_LEN` = 4, `m_ready` = 1 -> 8 back-to-back transfers in order; `m_last` on 0x04 and 0x08; `pkt_count` = 2.
- **Backpressure:** `m_ready` = 0 with 8 words in the FIFO -> exactly 3 reads and `occ` = 3; `m_data` holds 0x01 stable. Then `m_ready` = 1 -> 0x01..0x08 transfer with no gaps.
- **Random `m_ready`** (50% duty) over 64 words -> a scoreboard sees order intact; `fifo_r_en` is never high while `fifo_empty` is high; `m_valid` never drops without a transfer.
- **Reset mid-operation:** assert `rst_n` low with `occ` = 2 and beat = 2 -> all outputs 0 immediately. After release, new data 0x10.. starts at beat 0; `m_last` lands on the 4th new word.
- **`pkt_count` wrap:** force `pkt_count` to 0xFFFF, complete one packet -> `pkt_count` = 0x0000.
